ise_sorter_param: RTL and testbench
===================================

Name: ise_sorter_param

Overview:
- Parametrised image-sort engine. Streams NUM_IMG images of PIX_PER_IMG RGB pixels each.
- Each image is classified by its dominant colour channel. For the winning channel, a fixed-point mean intensity is computed.
- Image indices are kept in one sorted list per colour, then emitted class by class over a valid/ready output.
- Sits between the pixel source and the result collector in the image-statistics subsystem. Successor of the fixed 32-image engine, adding parametrised sizing, selectable sort order, an input handshake and output back-pressure.

Parameters:
- NUM_IMG, 32, images per batch (2..64); IDX_W = clog2(NUM_IMG).
- PIX_PER_IMG, 16384, pixels per image (power of two ≥4); CNT_W = clog2(PIX_PER_IMG)+1.
- PIX_W, 8, bits per colour channel; pixel word width is 3*PIX_W as {R,G,B}.
- FRAC_W, 2, fractional bits of the mean; MEAN_W = PIX_W+FRAC_W; ACC_W = PIX_W+CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel_in valid.
- in_ready  out  1  engine accepts a pixel this cycle.
- pixel_in  in  3*PIX_W  {R,G,B}.
- sort_desc  in  1  0 = ascending mean, 1 = descending; sampled at the first pixel of a batch.
- out_valid  out  1  result valid.
- out_ready  in  1  collector accepts the result.
- color_index  out  2  0 = R, 1 = G, 2 = B.
- image_out_index  out  IDX_W  image number, 0-based in arrival order.
- batch_done  out  1  one-cycle pulse when the last result of a batch is accepted.

Behaviour:
- Reset: clears every register.
  - Outputs after reset: in_ready=1, out_valid=0, color_index=0, image_out_index=0, batch_done=0.
  - State = READ. Lists are empty, all counters are 0.
  - Reset asserted mid-batch aborts the batch with no partial output.
- Pixel class rule, from fixed tie priority R > G > B:
  - R if R≥G and R≥B.
  - else G if G≥B.
  - else B.
- Image class uses the same rule applied to the three per-channel pixel counts.
- In READ, in_ready=1. On each in_valid&&in_ready handshake:
  - The winning channel's count increments and its value is added to that channel's ACC_W accumulator.
  - The pixel counter increments.
- The handshake on pixel PIX_PER_IMG-1 moves the state to DIVIDE; in_ready=0 from the next cycle.
- DIVIDE:
  - Starts ise_divider with dividend = acc<<FRAC_W and divisor = winning count (always ≥1).
  - Quotient is floor; width is MEAN_W, no overflow possible.
  - Waits for div_done, then goes to INSERT.
- INSERT, one cycle:
  - Inserts {image_idx, mean} into the winning class list (depth NUM_IMG) using a parallel compare-and-shift.
  - The new entry goes after all entries with an equal mean, so ties keep arrival order in both sort modes.
  - Clears accumulators, channel counts and pixel counter; increments image_idx.
  - Returns to READ, or goes to OUTPUT if image_idx was NUM_IMG-1.
- OUTPUT:
  - Walks list R, then G, then B. Empty lists are skipped with no bubble cycle.
  - out_valid=1 with fields held stable until out_ready; the next entry is presented in the cycle after the handshake.
  - out_valid may stay high back-to-back at one result per cycle.
- Last handshake of a batch:
  - batch_done pulses in that same cycle.
  - Lists clear; state returns to READ with in_ready=1 on the next cycle.
- in_valid while in_ready=0 is ignored; pixel_in need not be held.
- Arithmetic is unsigned. Accumulators never wrap, since ACC_W covers PIX_PER_IMG·(2^PIX_W−1).

Decomposition:
- Package ise_pkg holds:
  - state enum {READ, DIVIDE, INSERT, OUTPUT};
  - colour enum {COL_R=0, COL_G=1, COL_B=2};
  - the class-decision function shared by the pixel and image rules.
- Sub-module ise_divider, parametrised by dividend and divisor widths:
  - Restoring divider, one quotient bit per cycle.
  - start/done handshake.
  - Latency = dividend width cycles, from start to done high.

Test Plan (NUM_IMG=4, PIX_PER_IMG=4, PIX_W=8, FRAC_W=2 unless noted):
- All-red images with R = 10, 20, 30, 40 for images 0..3, sort_desc=0 -> outputs (0,0),(0,1),(0,2),(0,3), then batch_done. Check means 40, 80, 120, 160 internally.
- Tie handling: pixel (50,50,50) -> R class. An image with two G pixels (0,60,10) and two B pixels (0,10,60) -> class G. Mean = floor(4·120/2) = 240.
- Sort and stability with sort_desc=1: R means 100, 200, 200 for images 0, 1, 3; image 2 blue -> R list 1, 3, 0, then (2,2). Equal means keep arrival order.
- Back-pressure: out_ready toggles 1,0,0,1 -> each result held stable while stalled, no result lost or duplicated. in_ready stays 0 until one cycle after the last handshake.
- Input stalls: in_valid deasserted randomly -> results identical to the unstalled run. Default parameters with 32 images × 16384 pixels match a golden model.
- reset_n pulsed low during DIVIDE of image 2 -> out_valid=0 immediately, in_ready=1. A fresh batch afterwards produces correct, uncontaminated results.

Source files
------------

// File: rtl/ise_pkg.sv
// Shared types and the dominant-channel decision for the image sort engine.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ise_pkg;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        DIVIDE = 2'd1,
        INSERT = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } colour_e;

    // Dominant channel with tie priority R > G > B; used for single pixels
    // and for the per-image channel counts alike.
    function automatic colour_e class_of(input logic [31:0] r,
                                         input logic [31:0] g,
                                         input logic [31:0] b);
        colour_e c;
        if (r >= g && r >= b) begin
            c = COL_R;
        end else if (g >= b) begin
            c = COL_G;
        end else begin
            c = COL_B;
        end
        return c;
    endfunction

endpackage

// File: rtl/ise_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle.
// Latency: DVD_W cycles from start to the one-cycle done pulse; quotient held until next start.
// Backpressure: none; a start while busy restarts the division.
module ise_divider #(
    parameter int DVD_W = 13,
    parameter int DVS_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int BL_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [DVD_W-1:0] work;
    logic [BL_W-1:0]  bits_left;
    logic             busy;

    logic [DVS_W-1:0] src_rem;
    logic [DVD_W-1:0] src_work;
    logic [DVS_W-1:0] src_dvs;
    logic [DVS_W:0]   trial;
    logic             fits;

    // The first quotient bit is resolved in the start cycle itself, so the
    // dividend shifts through 'work' while quotient bits enter at the bottom.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_work = start ? dividend : work;
        src_dvs  = start ? divisor : dvs;
        trial    = {src_rem, src_work[DVD_W-1]};
        fits     = trial >= {1'b0, src_dvs};
    end

    // One restoring step per cycle while busy; done pulses after the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem       <= '0;
            dvs       <= '0;
            work      <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem  <= fits ? DVS_W'(trial - {1'b0, src_dvs}) : trial[DVS_W-1:0];
                work <= {src_work[DVD_W-2:0], fits};
                dvs  <= src_dvs;
                if (start) begin
                    bits_left <= BL_W'(DVD_W - 1);
                    busy      <= 1'b1;
                end else begin
                    bits_left <= bits_left - BL_W'(1);
                    if (bits_left == BL_W'(1)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    assign quotient = work;

endmodule

// File: rtl/ise_sorter_param.sv
// Classifies each image by dominant channel, computes its mean, keeps sorted per-colour lists, emits them R,G,B.
// Latency: per image PIX_PER_IMG input cycles + divider + 1 insert cycle; results then at up to one per cycle.
// Backpressure: in_ready low outside READ; out_valid fields held until out_ready.
module ise_sorter_param
    import ise_pkg::*;
#(
    parameter  int NUM_IMG     = 32,
    parameter  int PIX_PER_IMG = 16384,
    parameter  int PIX_W       = 8,
    parameter  int FRAC_W      = 2,
    localparam int IDX_W       = $clog2(NUM_IMG),
    localparam int CNT_W       = $clog2(PIX_PER_IMG) + 1,
    localparam int MEAN_W      = PIX_W + FRAC_W,
    localparam int ACC_W       = PIX_W + CNT_W,
    localparam int DVD_W       = ACC_W + FRAC_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*PIX_W-1:0] pixel_in,
    input  logic               sort_desc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         color_index,
    output logic [IDX_W-1:0]   image_out_index,
    output logic               batch_done
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_IMG - 1);
    localparam logic [IDX_W-1:0] LAST_IMG = IDX_W'(NUM_IMG - 1);

    state_e state, state_nxt;

    logic [PIX_W-1:0]  pix_ch [0:2];
    logic [CNT_W-1:0]  cnt    [0:2];
    logic [ACC_W-1:0]  acc    [0:2];
    logic [CNT_W-1:0]  pix_cnt;
    logic [IDX_W-1:0]  image_idx;
    logic              desc_q;
    logic              div_start;
    logic              div_done;
    logic [DVD_W-1:0]  quot;
    logic [MEAN_W-1:0] new_mean;
    logic              unused_quot_hi;
    colour_e           pix_col;
    colour_e           img_col;

    logic [IDX_W-1:0]  lidx  [0:2][0:NUM_IMG-1];
    logic [MEAN_W-1:0] lmean [0:2][0:NUM_IMG-1];
    logic [IDX_W:0]    llen  [0:2];
    logic [NUM_IMG-1:0] ins_before;

    logic [1:0]        out_col;
    logic [IDX_W-1:0]  out_pos;
    logic              pos_last;
    logic              next_col_vld;
    colour_e           next_col;
    colour_e           first_col;
    logic              in_hs;
    logic              out_hs;

    assign pix_ch[0] = pixel_in[3*PIX_W-1:2*PIX_W];
    assign pix_ch[1] = pixel_in[2*PIX_W-1:PIX_W];
    assign pix_ch[2] = pixel_in[PIX_W-1:0];
    assign pix_col   = class_of(32'(pix_ch[0]), 32'(pix_ch[1]), 32'(pix_ch[2]));
    assign img_col   = class_of(32'(cnt[0]), 32'(cnt[1]), 32'(cnt[2]));

    assign new_mean       = quot[MEAN_W-1:0];
    assign unused_quot_hi = |quot[DVD_W-1:MEAN_W];
    assign in_hs          = in_valid && in_ready;
    assign out_hs         = out_valid && out_ready;

    assign color_index     = out_col;
    assign image_out_index = lidx[out_col][out_pos];

    ise_divider #(
        .DVD_W (DVD_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend ({acc[img_col], {FRAC_W{1'b0}}}),
        .divisor  (cnt[img_col]),
        .done     (div_done),
        .quotient (quot)
    );

    // Walk order: end of current list, then the next non-empty list, else batch end.
    always_comb begin
        pos_last     = ({1'b0, out_pos} + (IDX_W+1)'(1)) == llen[out_col];
        next_col_vld = 1'b0;
        next_col     = COL_B;
        if (out_col == COL_R && llen[1] != '0) begin
            next_col_vld = 1'b1;
            next_col     = COL_G;
        end else if (out_col != COL_B && llen[2] != '0) begin
            next_col_vld = 1'b1;
            next_col     = COL_B;
        end
        // First list to present once the final insert has landed.
        if (llen[0] != '0 || img_col == COL_R) begin
            first_col = COL_R;
        end else if (llen[1] != '0 || img_col == COL_G) begin
            first_col = COL_G;
        end else begin
            first_col = COL_B;
        end
    end

    // Entries that stay ahead of the new one: equal means stay ahead in both orders.
    always_comb begin
        ins_before = '0;
        for (int i = 0; i < NUM_IMG; i++) begin
            if ((IDX_W+1)'(i) < llen[img_col]) begin
                ins_before[i] = desc_q ? (lmean[img_col][i] >= new_mean)
                                       : (lmean[img_col][i] <= new_mean);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= READ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        batch_done = 1'b0;
        case (state)
            READ: begin
                in_ready = 1'b1;
                if (in_valid && pix_cnt == LAST_PIX) state_nxt = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) state_nxt = INSERT;
            end
            INSERT: begin
                state_nxt = (image_idx == LAST_IMG) ? OUTPUT : READ;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready && pos_last && !next_col_vld) begin
                    batch_done = 1'b1;
                    state_nxt  = READ;
                end
            end
            default: state_nxt = READ;
        endcase
    end

    // Accumulation, sorted insertion and output walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 3; c++) begin
                cnt[c]  <= '0;
                acc[c]  <= '0;
                llen[c] <= '0;
                for (int i = 0; i < NUM_IMG; i++) begin
                    lidx[c][i]  <= '0;
                    lmean[c][i] <= '0;
                end
            end
            pix_cnt   <= '0;
            image_idx <= '0;
            desc_q    <= 1'b0;
            div_start <= 1'b0;
            out_col   <= '0;
            out_pos   <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                READ: begin
                    if (in_hs) begin
                        cnt[pix_col] <= cnt[pix_col] + CNT_W'(1);
                        acc[pix_col] <= acc[pix_col] + ACC_W'(pix_ch[pix_col]);
                        pix_cnt      <= pix_cnt + CNT_W'(1);
                        if (pix_cnt == '0 && image_idx == '0) desc_q <= sort_desc;
                        if (pix_cnt == LAST_PIX) div_start <= 1'b1;
                    end
                end
                INSERT: begin
                    if (!ins_before[0]) begin
                        lidx[img_col][0]  <= image_idx;
                        lmean[img_col][0] <= new_mean;
                    end
                    for (int i = 1; i < NUM_IMG; i++) begin
                        if (!ins_before[i]) begin
                            lidx[img_col][i]  <= ins_before[i-1] ? image_idx : lidx[img_col][i-1];
                            lmean[img_col][i] <= ins_before[i-1] ? new_mean : lmean[img_col][i-1];
                        end
                    end
                    llen[img_col] <= llen[img_col] + (IDX_W+1)'(1);
                    for (int c = 0; c < 3; c++) begin
                        cnt[c] <= '0;
                        acc[c] <= '0;
                    end
                    pix_cnt <= '0;
                    if (image_idx == LAST_IMG) begin
                        image_idx <= '0;
                        out_col   <= first_col;
                        out_pos   <= '0;
                    end else begin
                        image_idx <= image_idx + IDX_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_hs) begin
                        if (!pos_last) begin
                            out_pos <= out_pos + IDX_W'(1);
                        end else if (next_col_vld) begin
                            out_col <= next_col;
                            out_pos <= '0;
                        end else begin
                            out_col <= '0;
                            out_pos <= '0;
                            for (int c = 0; c < 3; c++) begin
                                llen[c] <= '0;
                                for (int i = 0; i < NUM_IMG; i++) begin
                                    lidx[c][i]  <= '0;
                                    lmean[c][i] <= '0;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_sorter_param.sv
// Bench for the image sort engine with a small 4-image, 4-pixel configuration.
// Reference: per-image class/mean from plain arithmetic, then stable bucket ordering by mean.
// Drives on the falling edge, samples shortly after it.
module tb_ise_sorter_param;

    localparam int NI  = 4;
    localparam int PPI = 4;
    localparam int PW  = 8;
    localparam int FW  = 2;
    localparam int IW  = $clog2(NI);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3*PW-1:0] pixel_in = '0;
    logic          sort_desc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    color_index;
    logic [IW-1:0] image_out_index;
    logic          batch_done;

    int checks   = 0;
    int failures = 0;
    logic [3*PW-1:0] pix [NI*PPI];
    int exp_q[$];

    always #5 clk = ~clk;

    ise_sorter_param #(
        .NUM_IMG     (NI),
        .PIX_PER_IMG (PPI),
        .PIX_W       (PW),
        .FRAC_W      (FW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pixel_in        (pixel_in),
        .sort_desc       (sort_desc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .color_index     (color_index),
        .image_out_index (image_out_index),
        .batch_done      (batch_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3*PW-1:0] rgb(input int r, input int g, input int b);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic int cls(input int r, input int g, input int b);
        if (r >= g && r >= b) return 0;
        if (g >= b) return 1;
        return 2;
    endfunction

    // Expected result stream, encoded colour*256 + image index.
    task automatic build_exp(input bit desc);
        int mean [NI];
        int col  [NI];
        exp_q.delete();
        for (int img = 0; img < NI; img++) begin
            int cnt [3];
            int acc [3];
            for (int c = 0; c < 3; c++) begin
                cnt[c] = 0;
                acc[c] = 0;
            end
            for (int p = 0; p < PPI; p++) begin
                int ch [3];
                int c;
                ch[0] = int'(pix[img*PPI+p][23:16]);
                ch[1] = int'(pix[img*PPI+p][15:8]);
                ch[2] = int'(pix[img*PPI+p][7:0]);
                c = cls(ch[0], ch[1], ch[2]);
                cnt[c]++;
                acc[c] += ch[c];
            end
            col[img]  = cls(cnt[0], cnt[1], cnt[2]);
            mean[img] = (acc[col[img]] * (1 << FW)) / cnt[col[img]];
        end
        for (int c = 0; c < 3; c++) begin
            for (int step = 0; step < 1024; step++) begin
                int v;
                v = desc ? 1023 - step : step;
                for (int img = 0; img < NI; img++) begin
                    if (col[img] == c && mean[img] == v) exp_q.push_back(c * 256 + img);
                end
            end
        end
    endtask

    task automatic rand_batch();
        for (int k = 0; k < NI*PPI; k++) begin
            if ($urandom_range(0, 1) == 0)
                pix[k] = rgb($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            else
                pix[k] = rgb($urandom_range(0, 4) * 50, $urandom_range(0, 4) * 50, $urandom_range(0, 4) * 50);
        end
    endtask

    task automatic send(input int npix, input bit desc, input bit stall_en);
        int k = 0;
        int budget = 0;
        bit last_of_img = 1'b0;
        while (k < npix && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (last_of_img) begin
                chk("in_ready_low_after_image", 32'(in_ready), 0);
                last_of_img = 1'b0;
            end
            if (stall_en && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                pixel_in = 24'($urandom);
            end else begin
                in_valid  = 1'b1;
                pixel_in  = pix[k];
                sort_desc = (k == 0) ? desc : 1'($urandom_range(0, 1));
                if (in_ready) begin
                    last_of_img = (k % PPI) == PPI - 1;
                    k++;
                end
            end
        end
        if (k < npix) chk("send_timeout", 32'(k), 32'(npix));
        @(negedge clk);
        in_valid = 1'b0;
        pixel_in = 24'($urandom);
        if (last_of_img) chk("in_ready_low_after_image", 32'(in_ready), 0);
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic collect(input int rdy_mode);
        int budget = 0;
        int n = 0;
        bit started = 1'b0;
        logic [31:0] got;
        while (exp_q.size() > 0 && budget < 500) begin
            @(negedge clk);
            budget++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            n++;
            #1;
            if (out_valid) begin
                started = 1'b1;
                got = 32'(color_index) * 256 + 32'(image_out_index);
                chk("result", got, 32'(exp_q[0]));
                chk("in_ready_during_output", 32'(in_ready), 0);
                if (out_ready) begin
                    chk("batch_done", 32'(batch_done), (exp_q.size() == 1) ? 32'd1 : 32'd0);
                    void'(exp_q.pop_front());
                end else begin
                    chk("batch_done_stalled", 32'(batch_done), 0);
                end
            end else if (started) begin
                chk("out_valid_bubble", 32'(out_valid), 1);
            end
        end
        if (exp_q.size() > 0) chk("collect_timeout", 32'(exp_q.size()), 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("in_ready_after_batch", 32'(in_ready), 1);
        chk("out_valid_after_batch", 32'(out_valid), 0);
        chk("index_after_batch", 32'(image_out_index), 0);
    endtask

    initial begin
        bit d;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_color_index", 32'(color_index), 0);
        chk("rst_image_index", 32'(image_out_index), 0);
        chk("rst_batch_done", 32'(batch_done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // All-red images with rising intensity, ascending.
        for (int img = 0; img < NI; img++)
            for (int p = 0; p < PPI; p++) pix[img*PPI+p] = rgb(10 * (img + 1), 0, 0);
        build_exp(1'b0);
        send(NI*PPI, 1'b0, 1'b0);
        collect(0);

        // Tie priorities at pixel and image level.
        rand_batch();
        for (int p = 0; p < PPI; p++) pix[p] = rgb(50, 50, 50);
        pix[PPI+0] = rgb(0, 60, 10);
        pix[PPI+1] = rgb(0, 10, 60);
        pix[PPI+2] = rgb(0, 60, 10);
        pix[PPI+3] = rgb(0, 10, 60);
        build_exp(1'b0);
        send(NI*PPI, 1'b0, 1'b0);
        collect(0);

        // Descending order with equal means kept in arrival order.
        for (int p = 0; p < PPI; p++) begin
            pix[p]         = rgb(100, 0, 0);
            pix[PPI+p]     = rgb(200, 0, 0);
            pix[2*PPI+p]   = rgb(0, 0, 90);
            pix[3*PPI+p]   = rgb(200, 0, 0);
        end
        build_exp(1'b1);
        send(NI*PPI, 1'b1, 1'b0);
        collect(0);

        // Output back-pressure.
        rand_batch();
        build_exp(1'b0);
        send(NI*PPI, 1'b0, 1'b0);
        collect(1);

        // Random batches with input stalls and random sort order.
        for (int b = 0; b < 6; b++) begin
            rand_batch();
            d = 1'($urandom_range(0, 1));
            build_exp(d);
            send(NI*PPI, d, 1'b1);
            collect(2);
        end

        // Reset while image 2 is being divided, then a clean batch.
        rand_batch();
        send(3*PPI, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 0);
        chk("midreset_in_ready", 32'(in_ready), 1);
        chk("midreset_batch_done", 32'(batch_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        rand_batch();
        d = 1'($urandom_range(0, 1));
        build_exp(d);
        send(NI*PPI, d, 1'b1);
        collect(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
